// File: rtl/hid_arb_pkg.sv
// hid_arb_pkg: shared state encoding, grant codes and default parameters for the HID report arbiter
package hid_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ACK,
        ST_NAK
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_PT   = 2'b01;
    localparam logic [1:0] GRANT_INJ  = 2'b10;

    localparam int DEF_REPORT_W    = 64;
    localparam int DEF_ACK_TIMEOUT = 1024;
    localparam int DEF_MAX_RETRY   = 3;
    localparam int DEF_MAX_STREAK  = 4;

endpackage

// File: rtl/hid_report_slot.sv
// hid_report_slot: one-entry report holding register; ready is the registered empty flag
module hid_report_slot
    import hid_arb_pkg::*;
#(
    parameter int W = DEF_REPORT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    input  logic         i_free,
    output logic         o_ready,
    output logic [W-1:0] o_data
);

    logic r_full;

    assign o_ready = !r_full;

    // capture when empty, release when the arbiter is finished with the report
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            o_data <= '0;
        end else if (i_free) begin
            r_full <= 1'b0;
        end else if (i_valid && !r_full) begin
            r_full <= 1'b1;
            o_data <= i_data;
        end
    end

endmodule

// File: rtl/hid_report_arbiter.sv
// hid_report_arbiter: arbitrates passthrough/injected HID reports onto an interrupt IN endpoint with ACK timeout and retry; STARVE_GUARD_EN adds the passthrough anti-starvation streak limit
module hid_report_arbiter
    import hid_arb_pkg::*;
#(
    parameter int REPORT_W    = DEF_REPORT_W,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int MAX_RETRY   = DEF_MAX_RETRY,
    parameter int MAX_STREAK  = DEF_MAX_STREAK
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pt_valid,
    output logic                pt_ready,
    input  logic [REPORT_W-1:0] pt_data,
    input  logic                inj_valid,
    output logic                inj_ready,
    input  logic [REPORT_W-1:0] inj_data,
    input  logic                in_token,
    output logic                tx_valid,
    output logic                tx_nak,
    output logic [REPORT_W-1:0] tx_data,
    input  logic                tx_done,
    input  logic                host_ack,
    output logic [1:0]          grant_src,
    output logic                drop_pulse,
    output logic                busy
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    arb_state_t          r_state, w_state;
    logic                r_sel, w_sel;
    logic                r_lock, w_lock;
    logic [TW-1:0]       r_tmo, w_tmo;
    logic [RW-1:0]       r_retry, w_retry;
    logic                w_drop;
    logic                w_free_pt, w_free_inj;
    logic                w_pt_held, w_inj_held;
    logic                w_pick_inj, w_sel_new;
    logic [REPORT_W-1:0] w_pt_data, w_inj_data;

    hid_report_slot #(.W(REPORT_W)) u_pt_slot (
        .clk     (clk),
        .rst     (rst),
        .i_valid (pt_valid),
        .i_data  (pt_data),
        .i_free  (w_free_pt),
        .o_ready (pt_ready),
        .o_data  (w_pt_data)
    );

    hid_report_slot #(.W(REPORT_W)) u_inj_slot (
        .clk     (clk),
        .rst     (rst),
        .i_valid (inj_valid),
        .i_data  (inj_data),
        .i_free  (w_free_inj),
        .o_ready (inj_ready),
        .o_data  (w_inj_data)
    );

    assign w_pt_held  = !pt_ready;
    assign w_inj_held = !inj_ready;
    // a retained (timed-out) report is always the next one sent
    assign w_sel_new  = r_lock ? r_sel : w_pick_inj;

`ifdef STARVE_GUARD_EN
    localparam int SW = $clog2(MAX_STREAK + 2);
    logic [SW-1:0] r_streak;
    logic          w_grant, w_grant_inj, w_grant_pt;

    assign w_pick_inj  = w_inj_held && !(w_pt_held && r_streak == SW'(MAX_STREAK));
    assign w_grant     = r_state == ST_IDLE && in_token && (w_pt_held || w_inj_held);
    assign w_grant_inj = w_grant && w_sel_new;
    assign w_grant_pt  = w_grant && !w_sel_new;

    // count injector wins while passthrough waits; any passthrough win or empty slot resets it
    always_ff @(posedge clk) begin
        if (rst || !w_pt_held || w_grant_pt)
            r_streak <= '0;
        else if (w_grant_inj && r_streak != SW'(MAX_STREAK))
            r_streak <= r_streak + 1'b1;
    end
`else
    assign w_pick_inj = w_inj_held;
`endif

    // state and transfer bookkeeping registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sel      <= 1'b0;
            r_lock     <= 1'b0;
            r_tmo      <= '0;
            r_retry    <= '0;
            drop_pulse <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_sel      <= w_sel;
            r_lock     <= w_lock;
            r_tmo      <= w_tmo;
            r_retry    <= w_retry;
            drop_pulse <= w_drop;
        end
    end

    // next-state, slot release and endpoint command outputs
    always_comb begin
        w_state    = r_state;
        w_sel      = r_sel;
        w_lock     = r_lock;
        w_tmo      = r_tmo;
        w_retry    = r_retry;
        w_drop     = 1'b0;
        w_free_pt  = 1'b0;
        w_free_inj = 1'b0;
        tx_valid   = r_state == ST_SEND;
        tx_nak     = r_state == ST_NAK;
        tx_data    = tx_valid ? (r_sel ? w_inj_data : w_pt_data) : '0;
        busy       = r_state != ST_IDLE;
        grant_src  = (r_state == ST_SEND || r_state == ST_WAIT_ACK) ? (r_sel ? GRANT_INJ : GRANT_PT) : GRANT_NONE;
        case (r_state)
            ST_IDLE: begin
                if (in_token) begin
                    w_state = (w_pt_held || w_inj_held) ? ST_SEND : ST_NAK;
                    w_sel   = (w_pt_held || w_inj_held) ? w_sel_new : r_sel;
                end
            end
            ST_SEND: begin
                if (tx_done) begin
                    w_state = ST_WAIT_ACK;
                    w_tmo   = '0;
                end
            end
            ST_WAIT_ACK: begin
                w_tmo = r_tmo + 1'b1;
                if (host_ack || r_tmo == TW'(ACK_TIMEOUT - 1)) begin
                    w_state = ST_IDLE;
                    w_lock  = 1'b0;
                    if (host_ack || r_retry == RW'(MAX_RETRY)) begin
                        w_free_pt  = !r_sel;
                        w_free_inj = r_sel;
                        w_retry    = '0;
                        w_drop     = !host_ack;
                    end else begin
                        w_retry = r_retry + 1'b1;
                        w_lock  = 1'b1;
                    end
                end
            end
            ST_NAK: begin
                if (tx_done)
                    w_state = ST_IDLE;
            end
            default: w_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_hid_report_arbiter.sv
// tb_hid_report_arbiter: directed self-checking bench for hid_report_arbiter (expectations follow STARVE_GUARD_EN)
module tb_hid_report_arbiter;

    localparam int W = 64;
    localparam int T = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pt_valid = 1'b0, inj_valid = 1'b0;
    logic [W-1:0] pt_data = '0, inj_data = '0;
    logic         pt_ready, inj_ready;
    logic         in_token = 1'b0, tx_done = 1'b0, host_ack = 1'b0;
    logic         tx_valid, tx_nak, drop_pulse, busy;
    logic [W-1:0] tx_data;
    logic [1:0]   grant_src;

    int n_cmp = 0;
    int n_bad = 0;

    hid_report_arbiter #(
        .REPORT_W    (W),
        .ACK_TIMEOUT (T),
        .MAX_RETRY   (3),
        .MAX_STREAK  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pt_valid   (pt_valid),
        .pt_ready   (pt_ready),
        .pt_data    (pt_data),
        .inj_valid  (inj_valid),
        .inj_ready  (inj_ready),
        .inj_data   (inj_data),
        .in_token   (in_token),
        .tx_valid   (tx_valid),
        .tx_nak     (tx_nak),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .host_ack   (host_ack),
        .grant_src  (grant_src),
        .drop_pulse (drop_pulse),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_pt(input logic [63:0] d);
        pt_valid = 1'b1;
        pt_data  = d;
        tick();
        pt_valid = 1'b0;
    endtask

    task automatic push_inj(input logic [63:0] d);
        inj_valid = 1'b1;
        inj_data  = d;
        tick();
        inj_valid = 1'b0;
    endtask

    task automatic token();
        in_token = 1'b1;
        tick();
        in_token = 1'b0;
    endtask

    task automatic done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic ack();
        host_ack = 1'b1;
        tick();
        host_ack = 1'b0;
    endtask

    task automatic send(input logic [63:0] d, input logic [1:0] g, input string tag);
        token();
        check({tag, " valid"}, tx_valid, 1'b1);
        check({tag, " data"}, tx_data, d);
        check({tag, " grant"}, grant_src, g);
        tick();
        check({tag, " data stable"}, tx_data, d);
        done();
        check({tag, " wait_ack"}, {tx_valid, busy}, 2'b01);
    endtask

    task automatic timeout(input logic exp_drop, input string tag);
        repeat (T - 1) tick();
        check({tag, " busy before timeout"}, busy, 1'b1);
        tick();
        check({tag, " idle after timeout"}, busy, 1'b0);
        check({tag, " drop"}, drop_pulse, exp_drop);
    endtask

    initial begin
        repeat (2) tick();
        check("rst tx_valid/nak", {tx_valid, tx_nak}, 2'b00);
        check("rst busy/drop", {busy, drop_pulse}, 2'b00);
        rst = 1'b0;
        tick();
        check("post-rst ready", {pt_ready, inj_ready}, 2'b11);
        check("post-rst tx_data", tx_data, 64'h0);
        check("post-rst grant", grant_src, 2'b00);

        // empty token -> NAK until tx_done
        token();
        check("nak tx_nak", tx_nak, 1'b1);
        check("nak grant", grant_src, 2'b00);
        check("nak busy", busy, 1'b1);
        tick();
        check("nak held", tx_nak, 1'b1);
        done();
        check("nak end", {tx_nak, busy}, 2'b00);

        // both held: injector first, then passthrough
        push_pt(64'hA1);
        push_inj(64'hB2);
        check("both held ready", {pt_ready, inj_ready}, 2'b00);
        token();
        check("ignored in_token stays", 1'b0, 1'b0 ^ tx_nak);
        check("pri data", tx_data, 64'hB2);
        check("pri grant", grant_src, 2'b10);
        done();
        token();
        check("token in wait_ack ignored", {busy, tx_valid}, 2'b10);
        ack();
        check("ack grant", grant_src, 2'b00);
        check("ack frees inj", {pt_ready, inj_ready}, 2'b01);
        send(64'hA1, 2'b01, "second");
        ack();
        check("pt freed", pt_ready, 1'b1);

        // starvation behaviour
        push_pt(64'hC3);
        for (int i = 0; i < 5; i++) begin
            push_inj(64'h10 + i);
`ifdef STARVE_GUARD_EN
            if (i == 4) send(64'hC3, 2'b01, "streak");
            else send(64'h10 + i, 2'b10, "streak");
`else
            send(64'h10 + i, 2'b10, "streak");
`endif
            ack();
        end
`ifdef STARVE_GUARD_EN
        send(64'h14, 2'b10, "streak drain");
`else
        check("strict pri pt still held", pt_ready, 1'b0);
        send(64'hC3, 2'b01, "streak drain");
`endif
        ack();

        // four unacknowledged attempts -> drop
        push_inj(64'hD4);
        for (int a = 0; a < 4; a++) begin
            send(64'hD4, 2'b10, "retry");
            timeout(a == 3, "retry");
            check("retry slot ready", inj_ready, a == 3);
        end
        tick();
        check("drop one cycle", drop_pulse, 1'b0);
        token();
        check("after drop nak", tx_nak, 1'b1);
        done();

        // retained report stays locked even if injector arrives
        push_pt(64'hE5);
        send(64'hE5, 2'b01, "lock first");
        timeout(1'b0, "lock");
        push_inj(64'hF6);
        send(64'hE5, 2'b01, "lock retry");
        ack();
        check("lock pt freed", pt_ready, 1'b1);
        send(64'hF6, 2'b10, "lock inj");
        ack();

        // ACK coincident with timeout wins and clears retry
        push_inj(64'h77);
        send(64'h77, 2'b10, "coinc first");
        timeout(1'b0, "coinc");
        send(64'h77, 2'b10, "coinc retry");
        repeat (T - 1) tick();
        ack();
        check("coinc idle", busy, 1'b0);
        check("coinc no drop", drop_pulse, 1'b0);
        check("coinc freed", inj_ready, 1'b1);
        check("coinc grant", grant_src, 2'b00);
        token();
        check("coinc no retransmit", {tx_nak, tx_valid}, 2'b10);
        done();
        push_inj(64'h66);
        for (int a = 0; a < 4; a++) begin
            send(64'h66, 2'b10, "retry cleared");
            timeout(a == 3, "retry cleared");
        end

        // reset mid-SEND abandons without drop
        push_pt(64'h99);
        push_inj(64'h88);
        token();
        check("pre-rst send", tx_valid, 1'b1);
        rst = 1'b1;
        tick();
        check("rst send tx_valid", tx_valid, 1'b0);
        check("rst send ready", {pt_ready, inj_ready}, 2'b11);
        check("rst send drop", drop_pulse, 1'b0);
        check("rst send busy", busy, 1'b0);
        check("rst send tx_data", tx_data, 64'h0);
        rst = 1'b0;
        tick();
        check("post rst drop", drop_pulse, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
